entrada_senha: RTL and testbench



---
 rtl/entrada_senha_pkg.sv | 36 +++
 rtl/entrada_senha_if.sv | 32 +++
 rtl/entrada_senha_temporizador.sv | 32 +++
 rtl/entrada_senha.sv | 196 +++++++++++++++++++
 tb/tb_entrada_senha.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/entrada_senha_pkg.sv
// Shared types and constants for the password-entry controller.
// Holds the keypad key codes, the controller state encoding, the status
// bundle driven towards the lock application, and a digit classifier.
package entrada_senha_pkg;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [KEY_W-1:0] KEY_ENTER     = 4'hE;
  localparam logic [KEY_W-1:0] KEY_CLEAR     = 4'hF;
  localparam logic [KEY_W-1:0] KEY_SET       = 4'hA;
  localparam logic [KEY_W-1:0] KEY_DIGIT_MAX = 4'h9;

  typedef enum logic [2:0] {
    ENTRY,
    CHECK,
    OPEN,
    SET,
    LOCKED
  } estado_t;

  // Status bundle presented to the door/LED side.
  typedef struct packed {
    logic             aberto;
    logic             bloqueado;
    logic             configurando;
    logic             erro;
    logic [CNT_W-1:0] n_digitos;
  } status_t;

  // Keys 0..9 are digits; A..F are command keys.
  function automatic logic is_digit(input logic [KEY_W-1:0] k);
    return k <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/entrada_senha_if.sv
// Keypad-to-lock bundle.
// master: keypad scanner side (drives ready/tecla, observes lock status).
// slave : password controller (consumes ready/tecla, drives lock status).
//   ready        key-down level flag from the scanner
//   tecla        registered key code from the scanner
//   aberto       door open window active
//   bloqueado    lockout active
//   configurando password-change mode active
//   erro         one-cycle failure pulse
//   n_digitos    digits currently buffered
interface entrada_senha_if;
  import entrada_senha_pkg::*;

  logic             ready;
  logic [KEY_W-1:0] tecla;
  logic             aberto;
  logic             bloqueado;
  logic             configurando;
  logic             erro;
  logic [CNT_W-1:0] n_digitos;

  modport master (
    output ready, tecla,
    input  aberto, bloqueado, configurando, erro, n_digitos
  );

  modport slave (
    input  ready, tecla,
    output aberto, bloqueado, configurando, erro, n_digitos
  );

endinterface

// File: rtl/entrada_senha_temporizador.sv
// Loadable down-counter shared by the open window and the lockout.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   load      loads value into the counter (wins over counting)
//   value     count to load
//   zero      counter has reached zero (saturates there)
module temporizador #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count_q;

  // Count down and hold at zero until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/entrada_senha.sv
// Password-entry controller downstream of the 4x4 keypad scanner.
// Turns each rising of ready into exactly one key event, buffers digits,
// checks the password, opens the door for a timed window, allows changing
// the password from the open state and locks out after repeated failures.
// Ports:
//   clk   sole clock
//   rst   synchronous active-high reset
//   bus   slave side of entrada_senha_if (ready/tecla in, status out)
module entrada_senha
  import entrada_senha_pkg::*;
#(
  parameter int unsigned          DIGITS      = 4,
  parameter logic [4*DIGITS-1:0]  DEFAULT_PW  = 16'h1234,
  parameter int unsigned          MAX_TRIES   = 3,
  parameter int unsigned          OPEN_CYCLES = 250_000_000,
  parameter int unsigned          LOCK_CYCLES = 500_000_000
) (
  input logic            clk,
  input logic            rst,
  entrada_senha_if.slave bus
);

  localparam int unsigned BW      = 4 * DIGITS;
  localparam int unsigned MAX_CYC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);
  localparam int unsigned FW      = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  estado_t          state_q, state_n;
  logic             r1_q, r2_q;
  logic [BW-1:0]    buf_q, buf_n;
  logic [BW-1:0]    pw_q, pw_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [FW-1:0]    fails_q, fails_n;
  logic             erro_n;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_zero;
  status_t          status_q;

  logic ev;
  logic digit;
  logic full;
  logic match;

  // One event per press: r1 high while r2 still low.
  assign ev    = r1_q & ~r2_q;
  assign digit = is_digit(bus.tecla);
  assign full  = (cnt_q == CNT_W'(DIGITS));
  assign match = full && (buf_q == pw_q);

  temporizador #(.W(TW)) u_tmr (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_val),
    .zero  (tmr_zero)
  );

  // State register plus all datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ENTRY;
      r1_q     <= 1'b0;
      r2_q     <= 1'b0;
      buf_q    <= '0;
      pw_q     <= DEFAULT_PW;
      cnt_q    <= '0;
      fails_q  <= '0;
      status_q <= '0;
    end else begin
      state_q                <= state_n;
      r1_q                   <= bus.ready;
      r2_q                   <= r1_q;
      buf_q                  <= buf_n;
      pw_q                   <= pw_n;
      cnt_q                  <= cnt_n;
      fails_q                <= fails_n;
      status_q.aberto        <= (state_n == OPEN);
      status_q.bloqueado     <= (state_n == LOCKED);
      status_q.configurando  <= (state_n == SET);
      status_q.erro          <= erro_n;
      status_q.n_digitos     <= cnt_n;
    end
  end

  // Next-state, buffer, password and timer control.
  always_comb begin
    state_n  = state_q;
    buf_n    = buf_q;
    cnt_n    = cnt_q;
    pw_n     = pw_q;
    fails_n  = fails_q;
    erro_n   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      ENTRY: begin
        if (ev) begin
          if (digit) begin
            if (!full) begin
              buf_n = (buf_q << 4) | BW'(bus.tecla);
              cnt_n = cnt_q + CNT_W'(1);
            end
          end else if (bus.tecla == KEY_CLEAR) begin
            buf_n = '0;
            cnt_n = '0;
          end else if (bus.tecla == KEY_ENTER) begin
            state_n = CHECK;
          end
        end
      end

      CHECK: begin
        buf_n = '0;
        cnt_n = '0;
        if (match) begin
          state_n  = OPEN;
          fails_n  = '0;
          tmr_load = 1'b1;
          tmr_val  = TW'(OPEN_CYCLES - 1);
        end else begin
          erro_n = 1'b1;
          if (fails_q == FW'(MAX_TRIES - 1)) begin
            state_n  = LOCKED;
            fails_n  = '0;
            tmr_load = 1'b1;
            tmr_val  = TW'(LOCK_CYCLES - 1);
          end else begin
            state_n = ENTRY;
            fails_n = fails_q + FW'(1);
          end
        end
      end

      OPEN: begin
        // Expiry takes precedence; key exits land on ENTRY as well.
        if (tmr_zero) begin
          state_n = ENTRY;
        end else if (ev) begin
          if (bus.tecla == KEY_ENTER || bus.tecla == KEY_CLEAR) begin
            state_n = ENTRY;
          end else if (bus.tecla == KEY_SET) begin
            state_n = SET;
            buf_n   = '0;
            cnt_n   = '0;
          end
        end
      end

      SET: begin
        if (ev) begin
          if (digit) begin
            if (!full) begin
              buf_n = (buf_q << 4) | BW'(bus.tecla);
              cnt_n = cnt_q + CNT_W'(1);
            end
          end else if (bus.tecla == KEY_CLEAR) begin
            buf_n = '0;
            cnt_n = '0;
          end else if (bus.tecla == KEY_ENTER) begin
            buf_n = '0;
            cnt_n = '0;
            if (full) begin
              pw_n    = buf_q;
              state_n = ENTRY;
            end else begin
              erro_n = 1'b1;
            end
          end
        end
      end

      LOCKED: begin
        buf_n = '0;
        cnt_n = '0;
        if (tmr_zero) begin
          state_n = ENTRY;
        end
      end

      default: begin
        state_n = ENTRY;
        buf_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.aberto       = status_q.aberto;
  assign bus.bloqueado    = status_q.bloqueado;
  assign bus.configurando = status_q.configurando;
  assign bus.erro         = status_q.erro;
  assign bus.n_digitos    = status_q.n_digitos;

endmodule

// File: tb/tb_entrada_senha.sv
// Directed bench for entrada_senha with short open/lock windows.
module tb_entrada_senha;
  import entrada_senha_pkg::*;

  logic clk = 1'b0;
  logic rst;

  entrada_senha_if bus();

  entrada_senha #(
    .DIGITS      (4),
    .DEFAULT_PW  (16'h1234),
    .MAX_TRIES   (3),
    .OPEN_CYCLES (10),
    .LOCK_CYCLES (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] k;
    int         nd;
    int         ab;
    int         bl;
    int         cf;
    int         er;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] k, input int nd, input int ab,
                     input int bl, input int cf, input int er);
    vec_t v;
    v.k = k; v.nd = nd; v.ab = ab; v.bl = bl; v.cf = cf; v.er = er;
    tbl.push_back(v);
  endtask

  // Press a key from a negedge: status sampled 3 cycles after ready rises,
  // erro pulses counted over the whole 5-cycle press.
  task automatic press(input logic [3:0] k, output int nd, output int ab,
                       output int bl, output int cf, output int er);
    er = 0;
    bus.tecla = k;
    bus.ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (bus.erro) er++;
      if (i == 3) begin
        nd = int'(bus.n_digitos);
        ab = int'(bus.aberto);
        bl = int'(bus.bloqueado);
        cf = int'(bus.configurando);
        bus.ready = 1'b0;
      end
    end
  endtask

  task automatic key(input logic [3:0] k);
    int nd, ab, bl, cf, er;
    press(k, nd, ab, bl, cf, er);
  endtask

  // Short press used during lockout: high 2 cycles, low 1 cycle.
  task automatic raw(input logic [3:0] k);
    bus.tecla = k;
    bus.ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_idle(input string name);
    check({name, "_ab"}, int'(bus.aberto), 0);
    check({name, "_bl"}, int'(bus.bloqueado), 0);
    check({name, "_cf"}, int'(bus.configurando), 0);
    check({name, "_er"}, int'(bus.erro), 0);
    check({name, "_nd"}, int'(bus.n_digitos), 0);
  endtask

  initial begin
    int nd, ab, bl, cf, er;
    int bl_n, ab_n, er_n, nd_n, first;

    rst       = 1'b1;
    bus.ready = 1'b0;
    bus.tecla = 4'h0;

    // Main table: 1234# opens, '#' closes, clear, 5th digit, SET flow.
    add(4'h1,1,0,0,0,0); add(4'h2,2,0,0,0,0); add(4'h3,3,0,0,0,0); add(4'h4,4,0,0,0,0);
    add(4'hE,0,1,0,0,0); add(4'hE,0,0,0,0,0);
    add(4'h1,1,0,0,0,0); add(4'h2,2,0,0,0,0); add(4'hF,0,0,0,0,0);
    add(4'h1,1,0,0,0,0); add(4'h2,2,0,0,0,0); add(4'h3,3,0,0,0,0); add(4'h4,4,0,0,0,0);
    add(4'hE,0,1,0,0,0); add(4'hF,0,0,0,0,0);
    add(4'h1,1,0,0,0,0); add(4'h2,2,0,0,0,0); add(4'h3,3,0,0,0,0); add(4'h4,4,0,0,0,0);
    add(4'h5,4,0,0,0,0); add(4'hE,0,1,0,0,0);
    add(4'hA,0,0,0,1,0); add(4'h9,1,0,0,1,0); add(4'h8,2,0,0,1,0); add(4'hD,2,0,0,1,0);
    add(4'hE,0,0,0,1,1);
    add(4'h9,1,0,0,1,0); add(4'h8,2,0,0,1,0); add(4'h7,3,0,0,1,0); add(4'h6,4,0,0,1,0);
    add(4'hE,0,0,0,0,0);
    add(4'h1,1,0,0,0,0); add(4'h2,2,0,0,0,0); add(4'h3,3,0,0,0,0); add(4'h4,4,0,0,0,0);
    add(4'hE,0,0,0,0,1);
    add(4'h9,1,0,0,0,0); add(4'h8,2,0,0,0,0); add(4'hB,2,0,0,0,0);
    add(4'h7,3,0,0,0,0); add(4'h6,4,0,0,0,0); add(4'hE,0,1,0,0,0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    foreach (tbl[i]) begin
      press(tbl[i].k, nd, ab, bl, cf, er);
      check($sformatf("row%0d_nd", i), nd, tbl[i].nd);
      check($sformatf("row%0d_ab", i), ab, tbl[i].ab);
      check($sformatf("row%0d_bl", i), bl, tbl[i].bl);
      check($sformatf("row%0d_cf", i), cf, tbl[i].cf);
      check($sformatf("row%0d_er", i), er, tbl[i].er);
    end

    // Reset in SET with two digits buffered restores the default password.
    press(4'hA, nd, ab, bl, cf, er);
    check("set_enter_cf", cf, 1);
    key(4'h1);
    press(4'h2, nd, ab, bl, cf, er);
    check("set_two_nd", nd, 2);
    rst = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    rst = 1'b0;
    key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    press(4'hE, nd, ab, bl, cf, er);
    check("default_pw_ab", ab, 1);
    press(4'hF, nd, ab, bl, cf, er);
    check("close_ab", ab, 0);

    // Three failures lock out; presses during lockout change nothing.
    for (int t = 0; t < 2; t++) begin
      key(4'h1); key(4'h2); key(4'h3); key(4'h5);
      press(4'hE, nd, ab, bl, cf, er);
      check($sformatf("fail%0d_er", t), er, 1);
      check($sformatf("fail%0d_bl", t), bl, 0);
    end
    key(4'h1); key(4'h2); key(4'h3); key(4'h5);
    bus.tecla = 4'hE;
    bus.ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("lock_pre_bl", int'(bus.bloqueado), 0);
    bl_n = 0; ab_n = 0; er_n = 0; nd_n = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (bus.bloqueado) bl_n++;
          if (bus.aberto) ab_n++;
          if (bus.erro) er_n++;
          if (bus.n_digitos != 4'd0) nd_n++;
        end
      end
      begin
        @(negedge clk);
        bus.ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        raw(4'h1); raw(4'h2); raw(4'h3); raw(4'h4); raw(4'hE);
      end
    join
    check("lock_len", bl_n, 20);
    check("lock_ab", ab_n, 0);
    check("lock_er", er_n, 1);
    check("lock_nd", nd_n, 0);

    key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    press(4'hE, nd, ab, bl, cf, er);
    check("post_lock_ab", ab, 1);
    check("post_lock_er", er, 0);
    press(4'hF, nd, ab, bl, cf, er);
    check("post_lock_close", ab, 0);

    // Five digits then '#' held for 100 cycles: one event, full window.
    key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    press(4'h5, nd, ab, bl, cf, er);
    check("hold_nd4", nd, 4);
    bus.tecla = 4'hE;
    bus.ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("hold_pre_ab", int'(bus.aberto), 0);
    check("hold_pre_nd", int'(bus.n_digitos), 4);
    ab_n = 0; er_n = 0; first = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.aberto) begin
        ab_n++;
        if (first == 0) first = i;
      end
      if (bus.erro) er_n++;
    end
    bus.ready = 1'b0;
    check("hold_first", first, 1);
    check("open_len", ab_n, 10);
    check("hold_er", er_n, 0);
    repeat (3) @(negedge clk);
    check_idle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
